// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg
// Shared types and constants for the L1 tag controller and its tag array.
//   clog2()          : ceiling log2 for elaboration-time width math
//   l1_ctrl_state_t  : controller sequencing states
//   l1_access_t      : outcome of a tag lookup (hit / fill empty way / replace)
//   L1_DEF_*         : default geometry and the widths derived from it
package l1_cache_pkg;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_LRU_REQ,
    ST_LRU_WAIT,
    ST_UPDATE,
    ST_RESP
  } l1_ctrl_state_t;

  typedef enum logic [1:0] {
    ACC_HIT,
    ACC_FILL,
    ACC_REPLACE
  } l1_access_t;

  localparam int L1_DEF_WAY             = 4;
  localparam int L1_DEF_BLOCK_SIZE_BYTE = 16;
  localparam int L1_DEF_CACHE_SIZE_BYTE = 32768;
  localparam int L1_DEF_ADDR_WIDTH      = 32;
  localparam int L1_DEF_SET       = L1_DEF_CACHE_SIZE_BYTE / (L1_DEF_BLOCK_SIZE_BYTE * L1_DEF_WAY);
  localparam int L1_DEF_SET_INDEX = clog2(L1_DEF_SET);
  localparam int L1_DEF_OFFSET    = clog2(L1_DEF_BLOCK_SIZE_BYTE);
  localparam int L1_DEF_TAG_W     = L1_DEF_ADDR_WIDTH - L1_DEF_SET_INDEX - L1_DEF_OFFSET;

  // Way numbers exchanged with the LRU unit are always 5 bits wide.
  localparam int LRU_WAY_W = 5;
  localparam int STAT_W    = 32;
  // Wide enough for WAY+2 with WAY up to 16.
  localparam int SEQ_CNT_W = 5;

endpackage

// File: rtl/l1_tag_array.sv
// l1_tag_array
// SET x WAY tag store with one valid bit per entry.
//   clk, reset : clock; asynchronous active-high reset clears every valid bit
//   rd_idx     : set to read combinationally
//   rd_tags    : tags of all ways in rd_idx
//   rd_valid   : valid bits of all ways in rd_idx
//   wr_en      : write wr_tag into (wr_idx, wr_way) and mark it valid
// Tags themselves are not reset; a cleared valid bit makes them irrelevant.
module l1_tag_array
  import l1_cache_pkg::*;
#(
  parameter int SET   = L1_DEF_SET,
  parameter int WAY   = L1_DEF_WAY,
  parameter int TAG_W = L1_DEF_TAG_W,
  parameter int IDX_W = L1_DEF_SET_INDEX,
  parameter int WAY_W = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [IDX_W-1:0]            rd_idx,
  output logic [WAY-1:0][TAG_W-1:0]   rd_tags,
  output logic [WAY-1:0]              rd_valid,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [WAY_W-1:0]            wr_way,
  input  logic [TAG_W-1:0]            wr_tag
);

  logic [TAG_W-1:0] tag_mem [SET][WAY];
  logic [WAY-1:0]   valid_q [SET];

  always_ff @(posedge clk) begin
    if (wr_en) tag_mem[wr_idx][wr_way] <= wr_tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SET; s++) valid_q[s] <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx][wr_way] <= 1'b1;
    end
  end

  always_comb begin
    for (int w = 0; w < WAY; w++) rd_tags[w] = tag_mem[rd_idx][w];
    rd_valid = valid_q[rd_idx];
  end

endmodule

// File: rtl/l1_lru_ctrl.sv
// l1_lru_ctrl
// Set-associative L1 tag controller that acts as initiator towards the LRU
// replacement unit. One lookup at a time: classify as hit / fill / replace,
// issue a single-cycle LRU request, wait for the LRU unit, update the tag
// array and return the hit flag and 1-based way.
//   clk, reset            : clock; asynchronous active-high reset
//   req_valid/req_addr    : lookup request; req_ready high while accepting
//   resp_valid/hit/way    : one-cycle result strobe, hit flag, 1-based way
//   lru_start + qualifiers: one-cycle LRU request (found/updated/replace)
//   lru_index/way_index   : set index and 1-based way (0 for replace)
//   lru_replace_index     : 0-based victim, valid with lru_block_replace
//   hit/miss/evict_count  : saturating statistics
// Optional feature macro: L1_STATS_EN builds the statistics counters;
// without it the counter ports read 0 and no counter flops exist.
module l1_lru_ctrl
  import l1_cache_pkg::*;
#(
  parameter int WAY             = L1_DEF_WAY,
  parameter int BLOCK_SIZE_BYTE = L1_DEF_BLOCK_SIZE_BYTE,
  parameter int CACHE_SIZE_BYTE = L1_DEF_CACHE_SIZE_BYTE,
  parameter int ADDR_WIDTH      = L1_DEF_ADDR_WIDTH,
  localparam int SET       = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
  localparam int SET_INDEX = clog2(SET),
  localparam int OFFSET    = clog2(BLOCK_SIZE_BYTE),
  localparam int TAG_W     = ADDR_WIDTH - SET_INDEX - OFFSET
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [LRU_WAY_W-1:0]  resp_way,
  output logic                  lru_start,
  output logic                  lru_found_in_cache,
  output logic                  lru_updated,
  output logic                  lru_replace,
  output logic [SET_INDEX-1:0]  lru_index,
  output logic [LRU_WAY_W-1:0]  lru_way_index,
  input  logic [LRU_WAY_W-1:0]  lru_replace_index,
  input  logic                  lru_block_replace,
  output logic [STAT_W-1:0]     hit_count,
  output logic [STAT_W-1:0]     miss_count,
  output logic [STAT_W-1:0]     evict_count
);

  localparam int WAY_W = (WAY > 1) ? clog2(WAY) : 1;

  l1_ctrl_state_t         state_q, state_d;
  logic [SEQ_CNT_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [SET_INDEX-1:0]   idx_q, idx_d;
  l1_access_t             acc_q, acc_d;
  logic [LRU_WAY_W-1:0]   way_q, way_d;

  logic [WAY-1:0][TAG_W-1:0] rd_tags;
  logic [WAY-1:0]            rd_valid;
  logic                      wr_en;

  logic                 look_hit, look_free;
  logic [LRU_WAY_W-1:0] look_hit_way, look_free_way;

  // Byte-offset bits never influence a lookup.
  logic unused_offset;
  assign unused_offset = ^req_addr[OFFSET-1:0];

  l1_tag_array #(
    .SET   (SET),
    .WAY   (WAY),
    .TAG_W (TAG_W),
    .IDX_W (SET_INDEX),
    .WAY_W (WAY_W)
  ) u_tag_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx_q),
    .rd_tags  (rd_tags),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_idx   (idx_q),
    .wr_way   (WAY_W'(way_q - 5'd1)),
    .wr_tag   (tag_q)
  );

  // First matching valid way and first invalid way, both 1-based.
  always_comb begin
    look_hit      = 1'b0;
    look_hit_way  = '0;
    look_free     = 1'b0;
    look_free_way = '0;
    for (int w = 0; w < WAY; w++) begin
      if (!look_hit && rd_valid[w] && (rd_tags[w] == tag_q)) begin
        look_hit     = 1'b1;
        look_hit_way = LRU_WAY_W'(w + 1);
      end
      if (!look_free && !rd_valid[w]) begin
        look_free     = 1'b1;
        look_free_way = LRU_WAY_W'(w + 1);
      end
    end
  end

  // cnt_q is shared: after reset it counts down the drain window in IDLE,
  // during LRU_WAIT it counts up the fixed hit/fill wait. It is always 0
  // when IDLE is re-entered from RESP, so back-to-back accepts are allowed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    way_d   = way_q;
    wr_en   = 1'b0;

    req_ready          = 1'b0;
    resp_valid         = 1'b0;
    resp_hit           = 1'b0;
    resp_way           = '0;
    lru_start          = 1'b0;
    lru_found_in_cache = 1'b0;
    lru_updated        = 1'b0;
    lru_replace        = 1'b0;
    lru_index          = '0;
    lru_way_index      = '0;

    case (state_q)
      ST_IDLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            tag_d   = req_addr[ADDR_WIDTH-1 -: TAG_W];
            idx_d   = req_addr[OFFSET +: SET_INDEX];
            state_d = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        if (look_hit) begin
          acc_d = ACC_HIT;
          way_d = look_hit_way;
        end else if (look_free) begin
          acc_d = ACC_FILL;
          way_d = look_free_way;
        end else begin
          acc_d = ACC_REPLACE;
          way_d = '0;
        end
        state_d = ST_LRU_REQ;
      end
      ST_LRU_REQ: begin
        lru_start          = 1'b1;
        lru_found_in_cache = (acc_q == ACC_HIT);
        lru_updated        = (acc_q == ACC_FILL);
        lru_replace        = (acc_q == ACC_REPLACE);
        lru_index          = idx_q;
        lru_way_index      = way_q;
        cnt_d              = '0;
        state_d            = ST_LRU_WAIT;
      end
      ST_LRU_WAIT: begin
        if (acc_q == ACC_REPLACE) begin
          if (lru_block_replace) begin
            way_d   = lru_replace_index + 5'd1;
            state_d = ST_UPDATE;
          end
        end else if (cnt_q == SEQ_CNT_W'(WAY)) begin
          cnt_d   = '0;
          state_d = ST_UPDATE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_UPDATE: begin
        wr_en   = (acc_q != ACC_HIT);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_hit   = (acc_q == ACC_HIT);
        resp_way   = way_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset preloads the drain window so an LRU update already in flight in
  // the (unreset) LRU unit can finish before a new request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= SEQ_CNT_W'(WAY + 2);
      tag_q   <= '0;
      idx_q   <= '0;
      acc_q   <= ACC_HIT;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      way_q   <= way_d;
    end
  end

`ifdef L1_STATS_EN
  logic [STAT_W-1:0] hit_count_q, hit_count_d;
  logic [STAT_W-1:0] miss_count_q, miss_count_d;
  logic [STAT_W-1:0] evict_count_q, evict_count_d;

  // Counted once per access in UPDATE; each counter sticks at all-ones.
  always_comb begin
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    evict_count_d = evict_count_q;
    if (state_q == ST_UPDATE) begin
      if (acc_q == ACC_HIT) begin
        if (hit_count_q != '1) hit_count_d = hit_count_q + 1'b1;
      end else begin
        if (miss_count_q != '1) miss_count_d = miss_count_q + 1'b1;
        if ((acc_q == ACC_REPLACE) && (evict_count_q != '1)) evict_count_d = evict_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q   <= '0;
      miss_count_q  <= '0;
      evict_count_q <= '0;
    end else begin
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
      evict_count_q <= evict_count_d;
    end
  end

  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;
  assign evict_count = evict_count_q;
`else
  assign hit_count   = '0;
  assign miss_count  = '0;
  assign evict_count = '0;
`endif

endmodule

// File: tb/tb_l1_lru_ctrl.sv
// tb_l1_lru_ctrl
// Self-checking bench for l1_lru_ctrl at default geometry (4 ways, 512 sets,
// index = addr[12:4], tag = addr[31:13]). The bench plays the LRU unit.
module tb_l1_lru_ctrl;

  localparam int WAY = 4;

`ifdef L1_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_hit;
  logic [4:0]  resp_way;
  logic        lru_start;
  logic        lru_found_in_cache;
  logic        lru_updated;
  logic        lru_replace;
  logic [8:0]  lru_index;
  logic [4:0]  lru_way_index;
  logic [4:0]  lru_replace_index;
  logic        lru_block_replace;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [31:0] evict_count;

  always #5 clk = ~clk;

  l1_lru_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_addr           (req_addr),
    .req_ready          (req_ready),
    .resp_valid         (resp_valid),
    .resp_hit           (resp_hit),
    .resp_way           (resp_way),
    .lru_start          (lru_start),
    .lru_found_in_cache (lru_found_in_cache),
    .lru_updated        (lru_updated),
    .lru_replace        (lru_replace),
    .lru_index          (lru_index),
    .lru_way_index      (lru_way_index),
    .lru_replace_index  (lru_replace_index),
    .lru_block_replace  (lru_block_replace),
    .hit_count          (hit_count),
    .miss_count         (miss_count),
    .evict_count        (evict_count)
  );

  int assert_count = 0;
  int fail_count   = 0;

  // Protocol monitor, sampled mid-cycle.
  int proto_viol   = 0;
  int accept_count = 0;
  int start_count  = 0;
  int exp_accepts  = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if ((lru_found_in_cache || lru_updated || lru_replace) && !lru_start) proto_viol++;
      if (lru_start && ((int'(lru_found_in_cache) + int'(lru_updated) + int'(lru_replace)) != 1)) proto_viol++;
      if (req_valid && req_ready) accept_count++;
      if (lru_start) start_count++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: per-set contents in way order plus access statistics.
  logic [18:0] m_tag   [512][WAY];
  bit          m_valid [512][WAY];
  int m_hits, m_misses, m_evicts;

  task automatic modelReset();
    for (int s = 0; s < 512; s++)
      for (int w = 0; w < WAY; w++) m_valid[s][w] = 1'b0;
    m_hits = 0; m_misses = 0; m_evicts = 0;
  endtask

  // Predicts and applies one access; qual is {found, updated, replace}.
  task automatic modelAccess(input logic [31:0] addr, input logic [4:0] victim,
                             output logic hit, output logic [4:0] way, output logic [2:0] qual);
    int s_idx, free_way, hit_way;
    logic [18:0] tag;
    s_idx = int'(addr[12:4]);
    tag = addr[31:13];
    hit_way = -1;
    free_way = -1;
    for (int w = WAY - 1; w >= 0; w--) begin
      if (m_valid[s_idx][w] && m_tag[s_idx][w] == tag) hit_way = w;
      if (!m_valid[s_idx][w]) free_way = w;
    end
    if (hit_way >= 0) begin
      hit = 1'b1; way = 5'(hit_way + 1); qual = 3'b100; m_hits++;
    end else begin
      hit = 1'b0; m_misses++;
      if (free_way >= 0) begin
        way = 5'(free_way + 1); qual = 3'b010;
      end else begin
        way = victim + 5'd1; qual = 3'b001; m_evicts++;
      end
      m_valid[s_idx][int'(way) - 1] = 1'b1;
      m_tag[s_idx][int'(way) - 1] = tag;
    end
  endtask

  // Observations of the last transaction.
  int          obs_starts, obs_resp_cyc, obs_pulse_cyc;
  bit          obs_busy_ready;
  logic        obs_hit;
  logic [4:0]  obs_way, obs_lru_way;
  logic [2:0]  obs_qual;
  logic [8:0]  obs_idx;
  bit          spurious_en = 1'b0;

  // Issues one request and acts as the LRU unit until the response strobe.
  task automatic applyStimulus(input logic [31:0] addr, input logic [4:0] victim, input int repl_delay);
    int cyc, pulse_at, waited;
    bit done;
    obs_starts = 0; obs_resp_cyc = -1; obs_pulse_cyc = -1; obs_busy_ready = 1'b0;
    obs_hit = 1'b0; obs_way = '0; obs_lru_way = '0; obs_qual = '0; obs_idx = '0;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    checkOutput("ready_before_request", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    exp_accepts++;
    cyc = 1; pulse_at = -1; done = 1'b0;
    while (!done && cyc < 100) begin
      if (lru_start) begin
        obs_starts++;
        obs_qual    = {lru_found_in_cache, lru_updated, lru_replace};
        obs_lru_way = lru_way_index;
        obs_idx     = lru_index;
        if (lru_replace) pulse_at = cyc + 1 + repl_delay;
      end
      if (cyc == pulse_at) begin
        lru_block_replace = 1'b1;
        lru_replace_index = victim;
        obs_pulse_cyc     = cyc;
      end else if (spurious_en && cyc == 1) begin
        lru_block_replace = 1'b1;
        lru_replace_index = 5'($urandom_range(0, 3));
      end else begin
        lru_block_replace = 1'b0;
      end
      if (req_ready) obs_busy_ready = 1'b1;
      if (resp_valid) begin
        obs_resp_cyc = cyc;
        obs_hit      = resp_hit;
        obs_way      = resp_way;
        done         = 1'b1;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
    lru_block_replace = 1'b0;
  endtask

  task automatic checkTxn(input string name, input logic exp_hit, input logic [4:0] exp_way,
                          input logic [2:0] exp_qual, input logic [4:0] exp_lru_way, input logic [8:0] exp_idx);
    int exp_lat;
    exp_lat = (exp_qual == 3'b001) ? obs_pulse_cyc + 2 : WAY + 5;
    checkOutput({name, " resp_seen"},  32'(obs_resp_cyc >= 0), 32'd1);
    checkOutput({name, " resp_hit"},   32'(obs_hit), 32'(exp_hit));
    checkOutput({name, " resp_way"},   32'(obs_way), 32'(exp_way));
    checkOutput({name, " lru_qual"},   32'(obs_qual), 32'(exp_qual));
    checkOutput({name, " lru_way"},    32'(obs_lru_way), 32'(exp_lru_way));
    checkOutput({name, " lru_index"},  32'(obs_idx), 32'(exp_idx));
    checkOutput({name, " lru_starts"}, 32'(obs_starts), 32'd1);
    checkOutput({name, " busy_ready"}, 32'(obs_busy_ready), 32'd0);
    checkOutput({name, " latency"},    32'(obs_resp_cyc), 32'(exp_lat));
  endtask

  // Called #1 after reset falls; counts cycles with req_ready low.
  task automatic checkDrain(input string name);
    int low_cycles;
    low_cycles = 0;
    while (!req_ready && low_cycles < 20) begin
      low_cycles++;
      @(posedge clk); #1;
    end
    checkOutput({name, " ready_low_cycles"}, 32'(low_cycles), 32'(WAY + 2));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  victim;
    int          delay;
    logic        exp_hit;
    logic [4:0]  exp_way;
    logic [2:0]  exp_qual;
    logic [4:0]  exp_lru_way;
    logic [8:0]  exp_idx;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        m_hit;
    logic [4:0]  m_way;
    logic [2:0]  m_qual;
    logic [31:0] addr;
    logic [4:0]  victim;
    int          resp_seen, first_resp, second_resp, cyc, acc0, st0;

    vecs[0] = '{32'h0000_1230, 5'd0, 0, 1'b0, 5'd1, 3'b010, 5'd1, 9'h123};
    vecs[1] = '{32'h0000_1230, 5'd0, 0, 1'b1, 5'd1, 3'b100, 5'd1, 9'h123};
    vecs[2] = '{32'h0001_1230, 5'd0, 0, 1'b0, 5'd2, 3'b010, 5'd2, 9'h123};
    vecs[3] = '{32'h0002_1230, 5'd0, 0, 1'b0, 5'd3, 3'b010, 5'd3, 9'h123};
    vecs[4] = '{32'h0003_1230, 5'd0, 0, 1'b0, 5'd4, 3'b010, 5'd4, 9'h123};
    vecs[5] = '{32'h0004_1230, 5'd0, 2, 1'b0, 5'd1, 3'b001, 5'd0, 9'h123};
    vecs[6] = '{32'h0000_1230, 5'd1, 1, 1'b0, 5'd2, 3'b001, 5'd0, 9'h123};

    reset = 1'b1; req_valid = 1'b0; req_addr = '0;
    lru_replace_index = '0; lru_block_replace = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs", 32'({req_ready, resp_valid, resp_hit, resp_way, lru_start,
                lru_found_in_cache, lru_updated, lru_replace, lru_index, lru_way_index}), 32'd0);
    checkOutput("reset counters", hit_count | miss_count | evict_count, 32'd0);
    reset = 1'b0;
    checkDrain("startup");

    $display("[TB] directed vector table");
    for (int i = 0; i < 7; i++) begin
      modelAccess(vecs[i].addr, vecs[i].victim, m_hit, m_way, m_qual);
      applyStimulus(vecs[i].addr, vecs[i].victim, vecs[i].delay);
      checkTxn($sformatf("vec%0d", i), vecs[i].exp_hit, vecs[i].exp_way, vecs[i].exp_qual,
               vecs[i].exp_lru_way, vecs[i].exp_idx);
      if (i == 1) begin
        checkOutput("stats hit after 2", hit_count, STATS_ON ? 32'd1 : 32'd0);
        checkOutput("stats miss after 2", miss_count, STATS_ON ? 32'd1 : 32'd0);
        checkOutput("stats evict after 2", evict_count, 32'd0);
      end
    end

    $display("[TB] reset during LRU wait");
    while (!req_ready) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_addr = 32'h0000_1230;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_accepts++;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midop reset outputs", 32'({req_ready, resp_valid, resp_hit, resp_way, lru_start,
                lru_found_in_cache, lru_updated, lru_replace, lru_index, lru_way_index}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();
    checkDrain("midop");
    modelAccess(32'h0000_1230, 5'd0, m_hit, m_way, m_qual);
    applyStimulus(32'h0000_1230, 5'd0, 0);
    checkTxn("after_reset", 1'b0, 5'd1, 3'b010, 5'd1, 9'h123);

    $display("[TB] req_valid held high");
    acc0 = accept_count; st0 = start_count;
    req_valid = 1'b1; req_addr = 32'h0000_1238;
    resp_seen = 0; first_resp = -1; second_resp = -1; cyc = 0;
    while (resp_seen < 2 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (resp_valid) begin
        resp_seen++;
        checkOutput($sformatf("held resp%0d hit", resp_seen), 32'(resp_hit), 32'd1);
        checkOutput($sformatf("held resp%0d way", resp_seen), 32'(resp_way), 32'd1);
        if (resp_seen == 1) first_resp = cyc; else second_resp = cyc;
      end
    end
    req_valid = 1'b0;
    exp_accepts += 2;
    modelAccess(32'h0000_1238, 5'd0, m_hit, m_way, m_qual);
    modelAccess(32'h0000_1238, 5'd0, m_hit, m_way, m_qual);
    @(negedge clk);
    checkOutput("held accepts", 32'(accept_count - acc0), 32'd2);
    checkOutput("held lru_starts", 32'(start_count - st0), 32'd2);
    checkOutput("held back_to_back gap", 32'(second_resp - first_resp), 32'(WAY + 6));

    $display("[TB] randomized traffic against model");
    spurious_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      addr = {19'($urandom_range(0, 5)), 9'(9'h040 + 9'($urandom_range(0, 1))), 4'($urandom_range(0, 15))};
      victim = 5'($urandom_range(0, WAY - 1));
      modelAccess(addr, victim, m_hit, m_way, m_qual);
      applyStimulus(addr, victim, $urandom_range(0, 3));
      checkTxn($sformatf("rand%0d", n), m_hit, m_way, m_qual,
               (m_qual == 3'b001) ? 5'd0 : m_way, addr[12:4]);
    end
    spurious_en = 1'b0;

    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("protocol violations", 32'(proto_viol), 32'd0);
    checkOutput("total accepts", 32'(accept_count), 32'(exp_accepts));
    checkOutput("final hit_count", hit_count, STATS_ON ? 32'(m_hits) : 32'd0);
    checkOutput("final miss_count", miss_count, STATS_ON ? 32'(m_misses) : 32'd0);
    checkOutput("final evict_count", evict_count, STATS_ON ? 32'(m_evicts) : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
